// File: rtl/agc_stats_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : agc_stats_if                                                  |
// | Brief    : Lane-data, control and result bundle for agc_stats            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface agc_stats_if #(
  parameter int NBITS       = 5,
  parameter int NLANE       = 8,
  parameter int WINDOW_BITS = 24,
  parameter int ACC_BITS    = 32
);
  logic [NLANE*(NBITS-1)-1:0] abs_i;
  logic [NLANE-1:0]           gt_i;
  logic [NLANE-1:0]           lt_i;
  logic [WINDOW_BITS-1:0]     window_i;
  logic                       start_i;
  logic                       ack_i;
  logic                       busy_o;
  logic                       done_o;
  logic [ACC_BITS-1:0]        abs_sum_o;
  logic [ACC_BITS-1:0]        gt_cnt_o;
  logic [ACC_BITS-1:0]        lt_cnt_o;

  modport master (
    output abs_i, gt_i, lt_i, window_i, start_i, ack_i,
    input  busy_o, done_o, abs_sum_o, gt_cnt_o, lt_cnt_o
  );

  modport slave (
    input  abs_i, gt_i, lt_i, window_i, start_i, ack_i,
    output busy_o, done_o, abs_sum_o, gt_cnt_o, lt_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/agc_stats.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : agc_stats                                                     |
// | Brief    : Windowed AGC statistics: sum of |out|, above/below counts     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module agc_stats #(
  parameter int NBITS       = 5,
  parameter int NLANE       = 8,
  parameter int WINDOW_BITS = 24,
  parameter int ACC_BITS    = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  agc_stats_if.slave bus
);
  localparam int c_AW = NBITS - 1;
  localparam int c_CW = $clog2(NLANE + 1);
  localparam int c_SW = c_AW + c_CW;
  localparam logic [ACC_BITS-1:0] c_ACC_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  logic [WINDOW_BITS-1:0] r_win;
  logic [WINDOW_BITS-1:0] r_cnt;
  logic                   r_flush;
  logic                   r_busy;
  logic                   r_done;
  logic [ACC_BITS-1:0]    r_abs_out, r_gt_out, r_lt_out;
  logic [ACC_BITS-1:0]    r_abs_acc, r_gt_acc, r_lt_acc;
  logic [c_SW-1:0]        r_s1_abs;
  logic [c_CW-1:0]        r_s1_gt, r_s1_lt;
  logic                   r_s1_vld;

  logic [c_SW-1:0]        w_abs_red;
  logic [c_CW-1:0]        w_gt_red, w_lt_red;
  logic [WINDOW_BITS-1:0] w_win_eff;

  assign w_win_eff = (bus.window_i == '0) ? WINDOW_BITS'(1) : bus.window_i;

  function automatic logic [ACC_BITS-1:0] sat_add(input logic [ACC_BITS-1:0] a,
                                                  input logic [ACC_BITS-1:0] b);
    logic [ACC_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_BITS] ? c_ACC_MAX : s[ACC_BITS-1:0];
  endfunction

  always_comb begin
    w_abs_red = '0;
    w_gt_red  = '0;
    w_lt_red  = '0;
    for (int k = 0; k < NLANE; k++) begin
      w_abs_red = w_abs_red + c_SW'(bus.abs_i[k*c_AW +: c_AW]);
      w_gt_red  = w_gt_red + c_CW'(bus.gt_i[k]);
      w_lt_red  = w_lt_red + c_CW'(bus.lt_i[k]);
    end
  end

  // Stage 1: lane reduction, tagged valid only when captured during RUN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_abs <= '0;
      r_s1_gt  <= '0;
      r_s1_lt  <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_abs <= w_abs_red;
      r_s1_gt  <= w_gt_red;
      r_s1_lt  <= w_lt_red;
      r_s1_vld <= (r_state == S_RUN);
    end
  end

  // Stage 2: saturating accumulation
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == S_CLEAR) begin
      r_abs_acc <= '0;
      r_gt_acc  <= '0;
      r_lt_acc  <= '0;
    end else if (r_s1_vld) begin
      r_abs_acc <= sat_add(r_abs_acc, ACC_BITS'(r_s1_abs));
      r_gt_acc  <= sat_add(r_gt_acc, ACC_BITS'(r_s1_gt));
      r_lt_acc  <= sat_add(r_lt_acc, ACC_BITS'(r_s1_lt));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_win     <= '0;
      r_cnt     <= '0;
      r_flush   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_abs_out <= '0;
      r_gt_out  <= '0;
      r_lt_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_win   <= w_win_eff;
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_cnt   <= r_win;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= r_cnt - WINDOW_BITS'(1);
          if (r_cnt == WINDOW_BITS'(1)) begin
            r_state <= S_FLUSH;
            r_flush <= 1'b0;
          end
        end
        S_FLUSH: begin
          // Two cycles let the last RUN sample pass both pipeline stages
          if (r_flush) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_abs_out <= r_abs_acc;
            r_gt_out  <= r_gt_acc;
            r_lt_out  <= r_lt_acc;
          end else begin
            r_flush <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.start_i) begin
            r_win   <= w_win_eff;
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else if (bus.ack_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o    = r_busy;
  assign bus.done_o    = r_done;
  assign bus.abs_sum_o = r_abs_out;
  assign bus.gt_cnt_o  = r_gt_out;
  assign bus.lt_cnt_o  = r_lt_out;
endmodule
`default_nettype wire

// File: tb/tb_agc_stats.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_agc_stats                                                  |
// | Brief    : Table + random bench for agc_stats (32-bit and 8-bit acc)     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_agc_stats;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  longint m_abs, m_gt, m_lt;

  always #5 clk = ~clk;

  agc_stats_if #(.ACC_BITS(32)) if_a ();
  agc_stats_if #(.ACC_BITS(8))  if_b ();

  agc_stats #(.ACC_BITS(32)) dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  agc_stats #(.ACC_BITS(8))  dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));

  typedef struct {
    int           win;
    int           absv;
    logic [7:0]   gtv;
    logic [7:0]   ltv;
    longint       e_abs;
    longint       e_gt;
    longint       e_lt;
    longint       e_abs8;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint lane_sum(input logic [31:0] v);
    longint s = 0;
    for (int k = 0; k < 8; k++) s += longint'(v[k*4 +: 4]);
    return s;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic drive(input logic [31:0] av, input logic [7:0] g, input logic [7:0] l,
                       input logic s, input logic a, input logic [23:0] w);
    if_a.abs_i = av;  if_b.abs_i = av;
    if_a.gt_i = g;    if_b.gt_i = g;
    if_a.lt_i = l;    if_b.lt_i = l;
    if_a.start_i = s; if_b.start_i = s;
    if_a.ack_i = a;   if_b.ack_i = a;
    if_a.window_i = w; if_b.window_i = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one window starting in the current cycle; results checked in the first DONE cycle.
  task automatic do_window(input int win, input bit pat, input int absv, input logic [7:0] gtv,
                           input logic [7:0] ltv, input bit noise, input bit ack0);
    int weff;
    bit run;
    logic [31:0] av;
    logic [7:0]  g, l;
    logic        s, a;
    logic [23:0] w;
    longint pa, pg, pl, pb;
    weff = (win == 0) ? 1 : win;
    m_abs = 0; m_gt = 0; m_lt = 0;
    pa = 0; pg = 0; pl = 0; pb = 0;
    for (int off = 0; off <= weff + 4; off++) begin
      if (off == 0) begin
        pa = longint'(if_a.abs_sum_o); pg = longint'(if_a.gt_cnt_o);
        pl = longint'(if_a.lt_cnt_o);  pb = longint'(if_b.abs_sum_o);
      end
      if (off == 1) begin
        chk("busy_in_clear", longint'(if_a.busy_o), 1);
        chk("done_in_clear", longint'(if_a.done_o), 0);
      end
      if (off == weff + 3) begin
        chk("done_early", longint'(if_a.done_o), 0);
        chk("busy_flush", longint'(if_a.busy_o), 1);
        chk("hold_abs", longint'(if_a.abs_sum_o), pa);
        chk("hold_gt", longint'(if_a.gt_cnt_o), pg);
        chk("hold_lt", longint'(if_a.lt_cnt_o), pl);
        chk("hold_abs8", longint'(if_b.abs_sum_o), pb);
      end
      if (off == weff + 4) begin
        chk("done_time", longint'(if_a.done_o), 1);
        chk("done_time8", longint'(if_b.done_o), 1);
        chk("busy_done", longint'(if_a.busy_o), 0);
        chk("abs_sum", longint'(if_a.abs_sum_o), sat(m_abs, 64'hFFFF_FFFF));
        chk("gt_cnt", longint'(if_a.gt_cnt_o), sat(m_gt, 64'hFFFF_FFFF));
        chk("lt_cnt", longint'(if_a.lt_cnt_o), sat(m_lt, 64'hFFFF_FFFF));
        chk("abs_sum8", longint'(if_b.abs_sum_o), sat(m_abs, 255));
        chk("gt_cnt8", longint'(if_b.gt_cnt_o), sat(m_gt, 255));
        chk("lt_cnt8", longint'(if_b.lt_cnt_o), sat(m_lt, 255));
      end
      run = (off >= 2) && (off <= weff + 1);
      if (pat && run) begin
        av = {8{absv[3:0]}}; g = gtv; l = ltv;
      end else if (pat) begin
        av = '1; g = '1; l = '1;
      end else begin
        av = $urandom(); g = 8'($urandom()); l = 8'($urandom());
      end
      s = (off == 0);
      a = (off == 0) && ack0;
      if (noise && off >= 1 && off <= weff + 3) begin
        s = 1'($urandom_range(0, 1));
        a = 1'($urandom_range(0, 1));
      end
      w = (off == 0) ? 24'(win) : 24'($urandom());
      if (off == weff + 4) begin
        s = 1'b0; a = 1'b0;
      end
      drive(av, g, l, s, a, w);
      if (run) begin
        m_abs += lane_sum(av);
        m_gt  += longint'($countones(g));
        m_lt  += longint'($countones(l));
      end
      if (off < weff + 4) step();
    end
  endtask

  task automatic do_ack();
    drive('0, '0, '0, 1'b0, 1'b1, '0);
    step();
    drive('0, '0, '0, 1'b0, 1'b0, '0);
    chk("done_after_ack", longint'(if_a.done_o), 0);
    chk("busy_after_ack", longint'(if_a.busy_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 3, 8'h0F, 8'h00, 96, 16, 0, 96};
    vecs[1] = '{0, 1, 8'h00, 8'h00, 8, 0, 0, 8};
    vecs[2] = '{4, 15, 8'h00, 8'h00, 480, 0, 0, 255};
    vecs[3] = '{3, 15, 8'hFF, 8'hFF, 360, 24, 24, 255};
    vecs[4] = '{2, 7, 8'h00, 8'hAA, 112, 0, 8, 112};
    vecs[5] = '{5, 0, 8'h01, 8'h80, 0, 5, 5, 0};

    drive('0, '0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", longint'(if_a.busy_o), 0);
    chk("rst_done", longint'(if_a.done_o), 0);
    chk("rst_abs", longint'(if_a.abs_sum_o), 0);
    chk("rst_gt", longint'(if_a.gt_cnt_o), 0);
    chk("rst_lt", longint'(if_a.lt_cnt_o), 0);

    for (int i = 0; i < 6; i++) begin
      do_window(vecs[i].win, 1'b1, vecs[i].absv, vecs[i].gtv, vecs[i].ltv, (i % 2) == 1, 1'b0);
      chk("vec_abs", longint'(if_a.abs_sum_o), vecs[i].e_abs);
      chk("vec_gt", longint'(if_a.gt_cnt_o), vecs[i].e_gt);
      chk("vec_lt", longint'(if_a.lt_cnt_o), vecs[i].e_lt);
      chk("vec_abs8", longint'(if_b.abs_sum_o), vecs[i].e_abs8);
      step();
      chk("vec_stable", longint'(if_b.abs_sum_o), vecs[i].e_abs8);
      do_ack();
    end

    // Restart straight from DONE with start and ack together
    do_window(3, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    do_window(2, 1'b0, 0, '0, '0, 1'b0, 1'b1);
    do_ack();

    // Reset at RUN cycle 3 of a long window
    drive('1, '1, '1, 1'b1, 1'b0, 24'd8);
    step();
    for (int off = 1; off < 4; off++) begin
      drive($urandom(), 8'($urandom()), 8'($urandom()), 1'b0, 1'b0, '0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0, '0);
    chk("midrst_busy", longint'(if_a.busy_o), 0);
    chk("midrst_done", longint'(if_a.done_o), 0);
    chk("midrst_abs", longint'(if_a.abs_sum_o), 0);
    chk("midrst_gt", longint'(if_a.gt_cnt_o), 0);
    chk("midrst_lt", longint'(if_a.lt_cnt_o), 0);
    chk("midrst_abs8", longint'(if_b.abs_sum_o), 0);
    do_window(5, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    do_ack();

    for (int n = 0; n < 24; n++) begin
      do_window($urandom_range(0, 6), 1'b0, 0, '0, '0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
